// File: rtl/mmio_fifo_bank.sv
// Address-mapped bank of CH FIFOs with status, sticky error and transaction counter registers.
// Optional MMIO_FIFO_IRQ_EN adds a registered irq output raised while any error bit is set.
module mmio_fifo_bank #(
    parameter int DATA_W = 8,
    parameter int CH     = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
`ifdef MMIO_FIFO_IRQ_EN
    output logic              irq,
`endif
    output logic [DATA_W-1:0] counter_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] A_EMPTY = ADDR_W'(CH);
    localparam logic [ADDR_W-1:0] A_FULL  = ADDR_W'(CH + 1);
    localparam logic [ADDR_W-1:0] A_CNT   = ADDR_W'(CH + 2);
    localparam logic [ADDR_W-1:0] A_ERR   = ADDR_W'(CH + 3);

    logic [DATA_W-1:0] mem [CH][DEPTH];
    logic [PW-1:0]     wr_ptr [CH];
    logic [PW-1:0]     rd_ptr [CH];
    logic [PW:0]       count  [CH];

    logic [CH-1:0]     full, empty, push_req, pop_req, push_ok, pop_ok;
    logic [2*CH-1:0]   err, err_new, err_next;
    logic [DATA_W-1:0] rd_mux, counter_next;
    logic [1:0]        inc;
    logic              cnt_clr, err_clr;

    // All flags come from registered occupancy, so same-cycle push/pop see pre-cycle state.
    always_comb begin
        full     = '0;
        empty    = '0;
        push_req = '0;
        pop_req  = '0;
        for (int i = 0; i < CH; i++) begin
            full[i]     = (count[i] == (PW+1)'(DEPTH));
            empty[i]    = (count[i] == '0);
            push_req[i] = write_en && (write_address == ADDR_W'(i));
            pop_req[i]  = read_en && (read_address == ADDR_W'(i));
        end
        push_ok  = push_req & ~full;
        pop_ok   = pop_req & ~empty;
        err_new  = {pop_req & empty, push_req & full};
        cnt_clr  = write_en && (write_address == A_CNT);
        err_clr  = read_en && (read_address == A_ERR);
        err_next = (err_clr ? '0 : err) | err_new;
        inc      = {1'b0, |push_ok} + {1'b0, |pop_ok};
        counter_next = cnt_clr ? '0 : counter_out + DATA_W'(inc);
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CH; i++) begin
            if (read_address == ADDR_W'(i))
                rd_mux = pop_ok[i] ? mem[i][rd_ptr[i]] : '0;
        end
        if (read_address == A_EMPTY) rd_mux = DATA_W'(empty);
        if (read_address == A_FULL)  rd_mux = DATA_W'(full);
        if (read_address == A_CNT)   rd_mux = counter_out;
        if (read_address == A_ERR)   rd_mux = DATA_W'(err);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            read_data   <= '0;
            read_valid  <= 1'b0;
            counter_out <= '0;
            err         <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push_ok[i], pop_ok[i]})
                    2'b10:   count[i] <= count[i] + (PW+1)'(1);
                    2'b01:   count[i] <= count[i] - (PW+1)'(1);
                    default: count[i] <= count[i];
                endcase
            end
            read_valid <= read_en;
            if (read_en) read_data <= rd_mux;
            counter_out <= counter_next;
            err         <= err_next;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < CH; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= write_data;
        end
    end

`ifdef MMIO_FIFO_IRQ_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) irq <= 1'b0;
        else     irq <= |err;
    end
`endif

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Randomised and directed bench for mmio_fifo_bank against a queue-based reference model.
module tb_mmio_fifo_bank;
    localparam int DATA_W = 8;
    localparam int CH     = 2;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              write_en, read_en;
    logic [ADDR_W-1:0] write_address, read_address;
    logic [DATA_W-1:0] write_data;
    wire  [DATA_W-1:0] read_data, counter_out;
    wire               read_valid;
`ifdef MMIO_FIFO_IRQ_EN
    wire               irq;
`endif

    mmio_fifo_bank #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST),
        .write_en(write_en), .write_address(write_address), .write_data(write_data),
        .read_en(read_en), .read_address(read_address),
        .read_data(read_data), .read_valid(read_valid),
`ifdef MMIO_FIFO_IRQ_EN
        .irq(irq),
`endif
        .counter_out(counter_out)
    );

    always #5 CLK = ~CLK;

    typedef logic [7:0] byte_q_t[$];
    byte_q_t    q [CH];
    logic [7:0] m_rd;
    logic       m_valid;
    int         m_cnt;
    logic [3:0] m_err;
    logic       m_irq;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) q[i].delete();
        m_rd = 0; m_valid = 0; m_cnt = 0; m_err = 0; m_irq = 0;
    endtask

    // Drive one cycle and advance the model; returns at edge+1.
    task automatic do_op(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra);
        bit         pf [CH];
        bit         pe [CH];
        logic [3:0] new_err = 0;
        int         acc = 0;
        logic [7:0] rv = 0;
        for (int i = 0; i < CH; i++) begin
            pf[i] = (q[i].size() == DEPTH);
            pe[i] = (q[i].size() == 0);
        end
        write_en = we; write_address = wa; write_data = wd;
        read_en = re; read_address = ra;
        if (re) begin
            if (ra < CH) begin
                if (pe[ra]) new_err[CH + ra] = 1'b1;
                else begin rv = q[ra].pop_front(); acc++; end
            end else if (ra == CH) begin
                for (int i = 0; i < CH; i++) rv[i] = pe[i];
            end else if (ra == CH + 1) begin
                for (int i = 0; i < CH; i++) rv[i] = pf[i];
            end else if (ra == CH + 2) rv = m_cnt[7:0];
            else if (ra == CH + 3) rv = {4'b0, m_err};
        end
        if (we && wa < CH) begin
            if (pf[wa]) new_err[wa] = 1'b1;
            else begin q[wa].push_back(wd); acc++; end
        end
        m_irq = (m_err != 0);
        if (we && wa == CH + 2) m_cnt = 0;
        else m_cnt = (m_cnt + acc) % 256;
        if (re && ra == CH + 3) m_err = new_err;
        else m_err = m_err | new_err;
        if (re) m_rd = rv;
        m_valid = re;
        @(posedge CLK); #1;
        write_en = 0; read_en = 0;
    endtask

    task automatic hard_reset();
        RST = 1; #3; RST = 0;
        model_reset();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1; #2;
        n_cmp += 3;
        if (read_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd got %h exp 00", read_data); end
        if (read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", read_valid); end
        if (counter_out !== 8'h00) begin n_bad++; $display("FAIL reset_cnt got %h exp 00", counter_out); end
        RST = 0;
        model_reset();
        @(posedge CLK); #1;
    endtask

    task automatic test_defaults();
        logic [7:0] exp_c [3] = '{8'h03, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            do_op(0, 0, 0, 1, 3'(k + 2));
            n_cmp += 2;
            if (read_data !== exp_c[k] || read_data !== m_rd) begin
                n_bad++; $display("FAIL default_addr%0d got %h exp %h", k + 2, read_data, exp_c[k]);
            end
            if (read_valid !== 1'b1) begin n_bad++; $display("FAIL default_valid%0d got %b exp 1", k + 2, read_valid); end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++) do_op(1, 0, 8'hA1 + 8'(k), 0, 0);
        do_op(0, 0, 0, 1, 3);
        n_cmp++;
        if (read_data !== 8'h01) begin n_bad++; $display("FAIL full_flags got %h exp 01", read_data); end
        do_op(1, 0, 8'hA5, 0, 0);
        do_op(0, 0, 0, 1, 5);
        n_cmp++;
        if (read_data !== 8'h01) begin n_bad++; $display("FAIL overflow_err got %h exp 01", read_data); end
        do_op(0, 0, 0, 1, 5);
        n_cmp++;
        if (read_data !== 8'h00) begin n_bad++; $display("FAIL err_clear got %h exp 00", read_data); end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 4; k++) begin
            do_op(0, 0, 0, 1, 0);
            n_cmp += 2;
            if (read_data !== 8'hA1 + 8'(k)) begin n_bad++; $display("FAIL drain%0d got %h exp %h", k, read_data, 8'hA1 + 8'(k)); end
            if (read_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid%0d got %b exp 1", k, read_valid); end
            do_op(0, 0, 0, 0, 0);
            n_cmp += 2;
            if (read_valid !== 1'b0) begin n_bad++; $display("FAIL drain_idle%0d got %b exp 0", k, read_valid); end
            if (read_data !== 8'hA1 + 8'(k)) begin n_bad++; $display("FAIL drain_hold%0d got %h exp %h", k, read_data, 8'hA1 + 8'(k)); end
        end
        do_op(0, 0, 0, 1, 0);
        n_cmp++;
        if (read_data !== 8'h00) begin n_bad++; $display("FAIL underflow_rd got %h exp 00", read_data); end
        do_op(0, 0, 0, 1, 5);
        n_cmp += 2;
        if (read_data !== 8'h04) begin n_bad++; $display("FAIL underflow_err got %h exp 04", read_data); end
        if (counter_out !== 8'd8) begin n_bad++; $display("FAIL drain_cnt got %0d exp 8", counter_out); end
    endtask

    task automatic test_same_cycle();
        do_op(1, 1, 8'h5C, 1, 1);
        n_cmp++;
        if (read_data !== 8'h00) begin n_bad++; $display("FAIL empty_pushpop got %h exp 00", read_data); end
        do_op(0, 0, 0, 1, 5);
        n_cmp++;
        if (read_data !== 8'h08) begin n_bad++; $display("FAIL empty_pushpop_err got %h exp 08", read_data); end
        do_op(0, 0, 0, 1, 1);
        n_cmp++;
        if (read_data !== 8'h5C) begin n_bad++; $display("FAIL bypass_pop got %h exp 5c", read_data); end
        for (int k = 0; k < 4; k++) do_op(1, 1, 8'h10 + 8'(k), 0, 0);
        do_op(1, 1, 8'hEE, 1, 1);
        n_cmp++;
        if (read_data !== 8'h10) begin n_bad++; $display("FAIL full_pushpop got %h exp 10", read_data); end
        do_op(0, 0, 0, 1, 5);
        n_cmp++;
        if (read_data !== 8'h02) begin n_bad++; $display("FAIL full_pushpop_err got %h exp 02", read_data); end
        for (int k = 1; k < 4; k++) begin
            do_op(0, 0, 0, 1, 1);
            n_cmp++;
            if (read_data !== m_rd) begin n_bad++; $display("FAIL full_pushpop_drain%0d got %h exp %h", k, read_data, m_rd); end
        end
    endtask

    task automatic test_counter();
        do_op(1, 0, 8'h77, 0, 0);
        do_op(1, 4, 8'($urandom), 1, 0);
        n_cmp += 2;
        if (counter_out !== 8'h00) begin n_bad++; $display("FAIL cnt_clear got %h exp 00", counter_out); end
        if (read_data !== 8'h77) begin n_bad++; $display("FAIL cnt_clear_pop got %h exp 77", read_data); end
        for (int k = 0; k < 128; k++) begin
            do_op(1, 0, 8'(k), 0, 0);
            do_op(0, 0, 0, 1, 0);
        end
        n_cmp++;
        if (counter_out !== 8'h00 || counter_out !== m_cnt[7:0]) begin
            n_bad++; $display("FAIL cnt_wrap got %h exp 00", counter_out);
        end
    endtask

    task automatic test_random();
        logic we, re;
        logic [2:0] wa, ra;
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            do_op(we, wa, 8'($urandom), re, ra);
            n_cmp += 3;
            if (read_data !== m_rd) begin n_bad++; $display("FAIL rand_rd k=%0d got %h exp %h", k, read_data, m_rd); end
            if (read_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid k=%0d got %b exp %b", k, read_valid, m_valid); end
            if (counter_out !== m_cnt[7:0]) begin n_bad++; $display("FAIL rand_cnt k=%0d got %h exp %h", k, counter_out, m_cnt[7:0]); end
        end
    endtask

    task automatic test_async_reset();
        hard_reset();
        for (int k = 0; k < 3; k++) do_op(1, 0, 8'hC0 + 8'(k), 0, 0);
        do_op(0, 0, 0, 1, 0);
        read_en = 1; read_address = 0;
        #2; RST = 1; #1;
        n_cmp += 3;
        if (read_data !== 8'h00) begin n_bad++; $display("FAIL areset_rd got %h exp 00", read_data); end
        if (read_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b exp 0", read_valid); end
        if (counter_out !== 8'h00) begin n_bad++; $display("FAIL areset_cnt got %h exp 00", counter_out); end
        @(posedge CLK); #1;
        n_cmp++;
        if (read_valid !== 1'b0) begin n_bad++; $display("FAIL areset_inflight got %b exp 0", read_valid); end
        read_en = 0; RST = 0;
        model_reset();
        do_op(0, 0, 0, 1, 2);
        n_cmp++;
        if (read_data !== 8'h03) begin n_bad++; $display("FAIL areset_empty got %h exp 03", read_data); end
    endtask

`ifdef MMIO_FIFO_IRQ_EN
    task automatic test_irq();
        hard_reset();
        for (int k = 0; k < 5; k++) do_op(1, 1, 8'(k), 0, 0);
        do_op(0, 0, 0, 0, 0);
        n_cmp++;
        if (irq !== 1'b1 || irq !== m_irq) begin n_bad++; $display("FAIL irq_set got %b exp 1", irq); end
        do_op(0, 0, 0, 1, 5);
        do_op(0, 0, 0, 0, 0);
        n_cmp++;
        if (irq !== 1'b0 || irq !== m_irq) begin n_bad++; $display("FAIL irq_clear got %b exp 0", irq); end
    endtask
`endif

    initial begin
        RST = 1; write_en = 0; read_en = 0;
        write_address = 0; read_address = 0; write_data = 0;
        model_reset();
        #12;
        test_reset();
        test_defaults();
        test_overflow();
        test_drain();
        test_same_cycle();
        test_counter();
        test_random();
        test_async_reset();
`ifdef MMIO_FIFO_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout compared %0d exp finish", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
